// File: rtl/div_seq_32_if.sv
// Request/result bundle for the sequential divider.
// The master drives the operands and the start request. The slave (the divider)
// returns its status and the held result.
interface div_seq_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_seq_32.sv
// Multi-cycle restoring divider that produces one quotient bit per clock.
// Signed operands are divided as magnitudes, and the signs are applied in a
// single fixup cycle. The quotient and remainder registers hold their values
// until the next accepted start. The busy and done flags are registered from
// the current state, so each one appears one cycle after its state is entered.
module div_seq_32 #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    div_seq_32_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] rem_work;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_dvd;
    logic             sign_dvs;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes, one restoring step, and the sign-corrected results.
    // The step is WIDTH+1 bits wide because the shifted partial remainder can
    // exceed WIDTH bits when the divisor is large.
    always_comb begin
        dvd_mag_in = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_mag_in = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
        partial    = {rem_work, q_work[WIDTH-1]};
        ge         = (partial >= {1'b0, dvs_mag});
        diff       = partial - {1'b0, dvs_mag};
        q_fix      = (sign_dvd ^ sign_dvs) ? -q_work : q_work;
        r_fix      = sign_dvd ? -rem_work : rem_work;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            q_work    <= '0;
            rem_work  <= '0;
            dvs_mag   <= '0;
            sign_dvd  <= 1'b0;
            sign_dvs  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            busy <= (state == RUN) || (state == FIXUP);
            done <= (state == DONE);
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        // The sign flags are captured only for signed divides, so that
                        // the fixup step never alters an unsigned result.
                        sign_dvd <= bus.is_signed & bus.dividend[WIDTH-1];
                        sign_dvs <= bus.is_signed & bus.divisor[WIDTH-1];
                        q_work   <= dvd_mag_in;
                        rem_work <= '0;
                        dvs_mag  <= dvs_mag_in;
                        counter  <= CW'(WIDTH - 1);
                        div_zero <= 1'b0;
                        if (bus.divisor == '0) begin
                            quotient  <= '1;
                            remainder <= bus.dividend;
                            div_zero  <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    q_work   <= {q_work[WIDTH-2:0], ge};
                    rem_work <= ge ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
                    counter  <= counter - 1'b1;
                    if (counter == '0) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    state     <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.quotient  = quotient;
    assign bus.remainder = remainder;
    assign bus.div_zero  = div_zero;
endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32. Each operation is checked for its latency,
// quotient, remainder and div_zero flag, and for a done pulse that lasts one cycle.
module tb_div_seq_32;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   k_cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lat;
    int   done_seen;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    div_seq_32_if bus();

    div_seq_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one start cycle. The posedge that follows is the accept edge.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = sgn;
        bus.dividend  = a;
        bus.divisor   = b;
        k_cyc         = cyc + 1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Wait, with a bound, until done is high. The result is the number of edges after the accept edge.
    task automatic wait_done(output int l);
        while (bus.done !== 1'b1 && (cyc - k_cyc) < 100) @(negedge clk);
        l = cyc - k_cyc;
    endtask

    task automatic run(input string tag, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input int elat);
        int l;
        issue(sgn, a, b);
        wait_done(l);
        $display("op %s: s=%0d %h / %h -> q=%h r=%h dz=%0d lat=%0d",
                 tag, sgn, a, b, bus.quotient, bus.remainder, bus.div_zero, l);
        check({tag, " latency"}, 32'(l), 32'(elat));
        check({tag, " quotient"}, bus.quotient, eq);
        check({tag, " remainder"}, bus.remainder, er);
        check({tag, " div_zero"}, {31'd0, bus.div_zero}, {31'd0, edz});
        @(negedge clk);
        check({tag, " done pulse width"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        rst = 1'b1;
        #1;
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset quotient", bus.quotient, 32'd0);
        check("reset remainder", bus.remainder, 32'd0);
        check("reset div_zero", {31'd0, bus.div_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Unsigned 100/7, with busy checked while the divide runs.
        issue(1'b0, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("u100/7 busy mid-run", {31'd0, bus.busy}, 32'd1);
        wait_done(lat);
        $display("op u100/7: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        check("u100/7 latency", 32'(lat), 32'd34);
        check("u100/7 quotient", bus.quotient, 32'd14);
        check("u100/7 remainder", bus.remainder, 32'd2);
        check("u100/7 div_zero", {31'd0, bus.div_zero}, 32'd0);
        check("u100/7 busy at done", {31'd0, bus.busy}, 32'd0);

        run("s-7/2",    1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run("s7/-2",    1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0, 34);
        run("s-100/7",  1'b1, 32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
        run("u0x1234/0",1'b0, 32'h0000_1234, 32'd0,        32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1);
        run("s-5/0",    1'b1, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
        run("s-min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0, 34);
        run("umax/1",   1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,         1'b0, 34);
        run("umax/2^31",1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,        32'h7FFF_FFFF, 1'b0, 34);
        run("u-2/umax", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFE, 1'b0, 34);
        run("umax/64k", 1'b0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 34);

        // A start pulse in the middle of RUN is ignored.
        issue(1'b0, 32'd1000, 32'd33);
        repeat (5) @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd1;
        @(negedge clk);
        bus.start    = 1'b0;
        wait_done(lat);
        $display("op u1000/33 with mid-run start: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        check("midrun latency", 32'(lat), 32'd34);
        check("midrun quotient", bus.quotient, 32'd30);
        check("midrun remainder", bus.remainder, 32'd10);

        // Back to back: the next start is raised in the cycle where done is high.
        issue(1'b0, 32'd50, 32'd6);
        wait_done(lat);
        bus.start     = 1'b1;
        bus.is_signed = 1'b1;
        bus.dividend  = 32'hFFFF_FFCE;
        bus.divisor   = 32'd6;
        k_cyc         = cyc + 1;
        $display("op u50/6: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        check("b2b first latency", 32'(lat), 32'd34);
        check("b2b first quotient", bus.quotient, 32'd8);
        check("b2b first remainder", bus.remainder, 32'd2);
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b done drops", {31'd0, bus.done}, 32'd0);
        wait_done(lat);
        $display("op s-50/6: q=%h r=%h lat=%0d", bus.quotient, bus.remainder, lat);
        check("b2b second latency", 32'(lat), 32'd34);
        check("b2b second quotient", bus.quotient, 32'hFFFF_FFF8);
        check("b2b second remainder", bus.remainder, 32'hFFFF_FFFE);

        // An asynchronous reset during RUN aborts the divide without a done pulse.
        issue(1'b0, 32'd77, 32'd5);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        $display("op reset mid-run: busy=%0d done=%0d q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort quotient", bus.quotient, 32'd0);
        check("abort remainder", bus.remainder, 32'd0);
        check("abort div_zero", {31'd0, bus.div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        check("abort no done", 32'(done_seen), 32'd0);
        run("u1000/10 after reset", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
